dcache_direct_wt: RTL and testbench
===================================

// Module: dcache_direct_wt
// PURPOSE
//   Direct-mapped, write-through, no-write-allocate data cache between the MIPS core's data port and slow data memory.
//   Core-side hits complete in the request cycle with no stall. Read misses fetch a 4-word line through a
//   request/ready handshake. Every store is forwarded to memory. proc_stall freezes the core's PC and register writes.
// PARAMETERS
//   ADDR_W  30  word-address width (byte address bits [31:2])
//   LINES   8   number of cache lines; power of two, >= 2; IDX_W = log2(LINES)
// PORTS
//   clk          in   1        clock, rising edge
//   rst          in   1        asynchronous reset, active-high
//   proc_read    in   1        core load request, held until proc_stall = 0
//   proc_write   in   1        core store request, held until proc_stall = 0
//   proc_addr    in   ADDR_W   word address
//   proc_wdata   in   32       store data
//   proc_rdata   out  32       load data, valid when proc_read = 1 and proc_stall = 0
//   proc_stall   out  1        1 = request not complete; core must hold all inputs
//   mem_read     out  1        line-fill request
//   mem_write    out  1        single-word write request
//   mem_addr     out  ADDR_W   word address; bits [1:0] = 0 for line fills
//   mem_wdata    out  32       write data (= proc_wdata)
//   mem_rdata    in   128      fill line; word k at bits [32k+31:32k]
//   mem_ready    in   1        1-cycle pulse: request done, mem_rdata valid
// BEHAVIOUR
//   Address split: offset = addr[1:0]; index = addr[IDX_W+1:2]; tag = addr[ADDR_W-1:IDX_W+2].
//   Storage: per line, 1 valid bit, a tag and 4x32 data. hit = valid[index] & (tag match).
//   Reset (async, immediate):
//     - all valid bits cleared; FSM -> IDLE
//     - mem_read, mem_write, proc_stall = 0; proc_rdata = 0; mem_addr = 0
//     - data/tag arrays are not reset
//   FSM states: IDLE, FILL, WRITE.
//   IDLE:
//     - proc_write = 1: stall = 1; next state WRITE (write has priority if read and write are both 1).
//     - proc_read & hit: stall = 0; proc_rdata = data[index][offset] combinationally; stay in IDLE.
//     - proc_read & miss: stall = 1; next state FILL.
//     - No request: stall = 0.
//   FILL:
//     - mem_read = 1 and stall = 1; mem_addr = {proc_addr[ADDR_W-1:2], 2'b00}, held stable.
//     - On the edge where mem_ready = 1: write line, set tag, set valid; -> IDLE.
//     - The next cycle is a hit, so read-miss latency = memory wait + 2 cycles.
//   WRITE:
//     - mem_write = 1; mem_addr = proc_addr; mem_wdata = proc_wdata.
//     - stall = ~mem_ready. The core advances on the same edge the memory completes.
//     - On that edge: if hit, update data[index][offset] (valid/tag unchanged); -> IDLE.
//     - On a miss, no allocation.
//   Handshake: mem_read and mem_write are never both 1. A request is held unchanged until mem_ready.
//     mem_ready while no request is active is ignored.
//   Outputs mem_read, mem_write, mem_addr and proc_stall are combinational from the state register and
//     registered addresses; there are no glitches from mem_rdata.
//   Conflict misses overwrite the line. There is no dirty state, so no writeback.
//   proc_rdata is 0 whenever it is not a valid hit in IDLE.
// TESTING (ADDR_W = 30, LINES = 8)
//   1. rst, then read 0x10 -> stall = 1, mem_read = 1, mem_addr = 0x10. mem_ready after 3 cycles with
//      mem_rdata = {D3,D2,D1,D0} -> the following cycle has stall = 0 and proc_rdata = D0.
//   2. Read 0x13 right after test 1 -> same-cycle hit: stall = 0, proc_rdata = D3, mem_read stays 0.
//   3. Write 0x11 with 0xDEADBEEF -> mem_write = 1, mem_addr = 0x11, stall drops on the mem_ready cycle.
//      Then read 0x11 -> hit returning 0xDEADBEEF.
//   4. Write 0x40 (miss, index 0) -> memory written. Then read 0x40 -> miss (mem_read = 1): no allocate.
//   5. Read 0x30 (index 4, new tag) evicts the 0x10 line. Then read 0x10 -> miss again, refilled line returned.
//   6. Assert rst while FILL waits on mem_ready -> mem_read and stall drop the same cycle, the late
//      mem_ready is ignored, and read 0x10 afterwards misses.

Source files
------------

// File: rtl/dcache_if.sv
// Core-side and memory-side signal bundle for the write-through data cache.
// The slave modport is the cache's view; master is the core/memory side.
interface dcache_if #(
    parameter int ADDR_W = 30
);
    logic              proc_read;
    logic              proc_write;
    logic [ADDR_W-1:0] proc_addr;
    logic [31:0]       proc_wdata;
    logic [31:0]       proc_rdata;
    logic              proc_stall;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [127:0]      mem_rdata;
    logic              mem_ready;

    modport slave (
        input  proc_read,
        input  proc_write,
        input  proc_addr,
        input  proc_wdata,
        output proc_rdata,
        output proc_stall,
        output mem_read,
        output mem_write,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ready
    );

    modport master (
        output proc_read,
        output proc_write,
        output proc_addr,
        output proc_wdata,
        input  proc_rdata,
        input  proc_stall,
        input  mem_read,
        input  mem_write,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ready
    );
endinterface

// File: rtl/dcache_direct_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache.
// Hits complete in the request cycle; misses fill a 4-word line.
module dcache_direct_wt #(
    parameter int ADDR_W = 30,
    parameter int LINES  = 8
) (
    input  logic      clk,
    input  logic      rst,
    dcache_if.slave   bus
);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [127:0]      data_q [LINES];

    logic [IDX_W-1:0]  p_idx;
    logic [TAG_W-1:0]  p_tag;
    logic [1:0]        p_off;
    logic [IDX_W-1:0]  r_idx;
    logic [TAG_W-1:0]  r_tag;
    logic [1:0]        r_off;
    logic              p_hit;
    logic              r_hit;
    logic              fill_done;
    logic              wr_done;
    logic              start_req;
    logic [31:0]       hit_word;

    assign p_off = bus.proc_addr[1:0];
    assign p_idx = bus.proc_addr[IDX_W+1:2];
    assign p_tag = bus.proc_addr[ADDR_W-1:IDX_W+2];
    assign r_off = addr_q[1:0];
    assign r_idx = addr_q[IDX_W+1:2];
    assign r_tag = addr_q[ADDR_W-1:IDX_W+2];

    assign p_hit = valid_q[p_idx] && (tag_q[p_idx] == p_tag);
    assign r_hit = valid_q[r_idx] && (tag_q[r_idx] == r_tag);

    assign hit_word  = data_q[p_idx][{p_off, 5'b0} +: 32];
    assign fill_done = (state_q == FILL) && bus.mem_ready;
    assign wr_done   = (state_q == WRITE) && bus.mem_ready;
    assign start_req = (state_q == IDLE) &&
                       (bus.proc_write || (bus.proc_read && !p_hit));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The request address is captured so memory-side outputs stay stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            valid_q <= '0;
        end else begin
            if (start_req) begin
                addr_q <= bus.proc_addr;
            end
            if (fill_done) begin
                valid_q[r_idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fill_done) begin
            tag_q[r_idx]  <= r_tag;
            data_q[r_idx] <= bus.mem_rdata;
        end else if (wr_done && r_hit) begin
            data_q[r_idx][{r_off, 5'b0} +: 32] <= bus.proc_wdata;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.proc_write) begin
                    state_d = WRITE;
                end else if (bus.proc_read && !p_hit) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                if (bus.mem_ready) begin
                    state_d = IDLE;
                end
            end
            WRITE: begin
                if (bus.mem_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.mem_wdata = bus.proc_wdata;

    // Reset forces every request/stall output low immediately.
    always_comb begin
        bus.proc_stall = 1'b0;
        bus.proc_rdata = '0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.mem_addr   = '0;
        if (!rst) begin
            unique case (state_q)
                IDLE: begin
                    bus.proc_stall = bus.proc_write ||
                                     (bus.proc_read && !p_hit);
                    if (bus.proc_read && !bus.proc_write && p_hit) begin
                        bus.proc_rdata = hit_word;
                    end
                end
                FILL: begin
                    bus.mem_read   = 1'b1;
                    bus.proc_stall = 1'b1;
                    bus.mem_addr   = {addr_q[ADDR_W-1:2], 2'b00};
                end
                WRITE: begin
                    bus.mem_write  = 1'b1;
                    bus.proc_stall = !bus.mem_ready;
                    bus.mem_addr   = addr_q;
                end
                default: begin
                    bus.proc_stall = 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dcache_direct_wt.sv
// Directed bench for the write-through data cache.
// Drives on the falling edge and samples 1 ns later.
module tb_dcache_direct_wt;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    localparam logic [127:0] LINE_A  = {32'hA3A3_0003, 32'hA2A2_0002,
                                        32'hA1A1_0001, 32'hA0A0_0000};
    localparam logic [127:0] LINE_A2 = {32'h5353_0013, 32'h5252_0012,
                                        32'hDEAD_BEEF, 32'h5050_0010};
    localparam logic [127:0] LINE_B  = {32'hB3B3_0043, 32'hB2B2_0042,
                                        32'hB1B1_0041, 32'hB0B0_0040};
    localparam logic [127:0] LINE_C  = {32'hC3C3_0033, 32'hC2C2_0032,
                                        32'hC1C1_0031, 32'hC0C0_0030};

    dcache_if #(.ADDR_W(30)) bus ();

    dcache_direct_wt #(
        .ADDR_W(30),
        .LINES (8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic hit(input string t, input logic [29:0] a,
                       input logic [31:0] exp);
        @(negedge clk);
        bus.proc_read  = 1'b1;
        bus.proc_write = 1'b0;
        bus.proc_addr  = a;
        #1;
        check({t, "_stall"}, 32'(bus.proc_stall), 32'd0);
        check({t, "_rdata"}, bus.proc_rdata, exp);
        check({t, "_mread"}, 32'(bus.mem_read), 32'd0);
    endtask

    task automatic miss(input string t, input logic [29:0] a,
                        input logic [127:0] line, input logic [31:0] exp);
        @(negedge clk);
        bus.proc_read  = 1'b1;
        bus.proc_write = 1'b0;
        bus.proc_addr  = a;
        #1;
        check({t, "_stall0"}, 32'(bus.proc_stall), 32'd1);
        check({t, "_rdata0"}, bus.proc_rdata, 32'd0);
        @(negedge clk);
        #1;
        check({t, "_mread"}, 32'(bus.mem_read), 32'd1);
        check({t, "_mwrite"}, 32'(bus.mem_write), 32'd0);
        check({t, "_maddr"}, 32'(bus.mem_addr), 32'({a[29:2], 2'b00}));
        @(negedge clk);
        #1;
        check({t, "_wait"}, 32'(bus.proc_stall), 32'd1);
        @(negedge clk);
        bus.mem_rdata = line;
        bus.mem_ready = 1'b1;
        #1;
        check({t, "_rdycyc"}, 32'(bus.proc_stall), 32'd1);
        @(negedge clk);
        bus.mem_ready = 1'b0;
        #1;
        check({t, "_stall1"}, 32'(bus.proc_stall), 32'd0);
        check({t, "_rdata1"}, bus.proc_rdata, exp);
        check({t, "_mread1"}, 32'(bus.mem_read), 32'd0);
    endtask

    task automatic store(input string t, input logic [29:0] a,
                         input logic [31:0] d);
        @(negedge clk);
        bus.proc_read  = 1'b0;
        bus.proc_write = 1'b1;
        bus.proc_addr  = a;
        bus.proc_wdata = d;
        #1;
        check({t, "_stall0"}, 32'(bus.proc_stall), 32'd1);
        @(negedge clk);
        #1;
        check({t, "_mwrite"}, 32'(bus.mem_write), 32'd1);
        check({t, "_mread"}, 32'(bus.mem_read), 32'd0);
        check({t, "_maddr"}, 32'(bus.mem_addr), 32'(a));
        check({t, "_mwdata"}, bus.mem_wdata, d);
        check({t, "_stall1"}, 32'(bus.proc_stall), 32'd1);
        @(negedge clk);
        bus.mem_ready = 1'b1;
        #1;
        check({t, "_stall_rdy"}, 32'(bus.proc_stall), 32'd0);
        @(negedge clk);
        bus.mem_ready  = 1'b0;
        bus.proc_write = 1'b0;
        #1;
        check({t, "_mwrite_off"}, 32'(bus.mem_write), 32'd0);
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        rst            = 1'b1;
        bus.proc_read  = 1'b0;
        bus.proc_write = 1'b0;
        bus.proc_addr  = '0;
        bus.proc_wdata = '0;
        bus.mem_rdata  = '0;
        bus.mem_ready  = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_stall", 32'(bus.proc_stall), 32'd0);
        check("rst_mread", 32'(bus.mem_read), 32'd0);
        check("rst_mwrite", 32'(bus.mem_write), 32'd0);
        check("rst_rdata", bus.proc_rdata, 32'd0);
        check("rst_maddr", 32'(bus.mem_addr), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        miss("t1", 30'h10, LINE_A, 32'hA0A0_0000);
        hit("t2", 30'h13, 32'hA3A3_0003);

        store("t3w", 30'h11, 32'hDEAD_BEEF);
        hit("t3r", 30'h11, 32'hDEAD_BEEF);
        hit("t3r2", 30'h12, 32'hA2A2_0002);

        store("t4w", 30'h40, 32'h1234_5678);
        miss("t4r", 30'h40, LINE_B, 32'hB0B0_0040);
        hit("t4h", 30'h43, 32'hB3B3_0043);

        miss("t5a", 30'h30, LINE_C, 32'hC0C0_0030);
        miss("t5b", 30'h10, LINE_A2, 32'h5050_0010);
        hit("t5h", 30'h11, 32'hDEAD_BEEF);

        // Reset in the middle of a fill, then a stray mem_ready.
        @(negedge clk);
        bus.proc_read = 1'b1;
        bus.proc_addr = 30'h30;
        #1;
        check("t6_stall0", 32'(bus.proc_stall), 32'd1);
        @(negedge clk);
        #1;
        check("t6_mread", 32'(bus.mem_read), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("t6_rst_mread", 32'(bus.mem_read), 32'd0);
        check("t6_rst_stall", 32'(bus.proc_stall), 32'd0);
        check("t6_rst_maddr", 32'(bus.mem_addr), 32'd0);
        @(negedge clk);
        rst           = 1'b0;
        bus.proc_read = 1'b0;
        bus.mem_rdata = LINE_C;
        bus.mem_ready = 1'b1;
        #1;
        check("t6_late_mread", 32'(bus.mem_read), 32'd0);
        check("t6_late_stall", 32'(bus.proc_stall), 32'd0);
        @(negedge clk);
        bus.mem_ready = 1'b0;
        #1;
        check("t6_idle_mread", 32'(bus.mem_read), 32'd0);
        check("t6_idle_mwrite", 32'(bus.mem_write), 32'd0);
        @(negedge clk);
        bus.proc_read = 1'b1;
        bus.proc_addr = 30'h10;
        #1;
        check("t6_post_stall", 32'(bus.proc_stall), 32'd1);
        check("t6_post_rdata", bus.proc_rdata, 32'd0);
        @(negedge clk);
        #1;
        check("t6_post_mread", 32'(bus.mem_read), 32'd1);
        check("t6_post_maddr", 32'(bus.mem_addr), 32'h10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
